// File: rtl/tx_8b10b_framer.sv
// tx_8b10b_framer
// Frames a byte-wide valid/ready packet stream with K-character delimiters
// (SOP ... EOP), pads gaps with comma idles and owns the running-disparity
// loop around an external combinational 8b/10b encoder. One symbol advances
// per sym_en strobe from the downstream serializer.
module tx_8b10b_framer #(
  parameter logic [8:0]  IDLE_CHAR = 9'h1BC,
  parameter logic [8:0]  SOP_CHAR  = 9'h1FB,
  parameter logic [8:0]  EOP_CHAR  = 9'h1FD,
  parameter logic [8:0]  FILL_CHAR = 9'h1F7,
  parameter int unsigned MIN_IDLE  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_en,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic [8:0]  enc_datain,
  output logic        enc_dispin,
  input  logic        enc_dispout,
  output logic        underrun,
  input  logic        underrun_clr,
  output logic [15:0] pkt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_EOP  = 2'd2
  } state_t;

  // Idle counter saturates at 15, so MIN_IDLE is limited to 1..15.
  localparam logic [3:0] MIN_IDLE_C = 4'(MIN_IDLE);

  // Saturating increment for the idle-gap counter.
  function automatic logic [3:0] idle_inc(input logic [3:0] cnt);
    return (cnt == 4'd15) ? 4'd15 : (cnt + 4'd1);
  endfunction

  state_t      state_r;
  logic [3:0]  idle_cnt_r;
  logic [8:0]  enc_datain_r;
  logic        enc_dispin_r;
  logic        underrun_r;
  logic [15:0] pkt_cnt_r;
  logic        fill_s;
  logic        ready_s;

  // Decode the handshake and the underrun event for the current symbol slot.
  always_comb begin
    ready_s = 1'b0;
    fill_s  = 1'b0;
    if (sym_en && (state_r == ST_DATA)) begin
      ready_s = 1'b1;
      fill_s  = ~s_valid;
    end else begin
      ready_s = 1'b0;
      fill_s  = 1'b0;
    end
  end

  assign s_ready    = ready_s;
  assign enc_datain = enc_datain_r;
  assign enc_dispin = enc_dispin_r;
  assign underrun   = underrun_r;
  assign pkt_cnt    = pkt_cnt_r;

  // Framing FSM: picks the next symbol and closes the disparity loop per strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idle_cnt_r   <= 4'd0;
      enc_datain_r <= IDLE_CHAR;
      enc_dispin_r <= 1'b0;
      pkt_cnt_r    <= 16'd0;
    end else if (sym_en) begin
      // The encoder is combinational: its output disparity belongs to the
      // symbol currently presented, and seeds the next one.
      enc_dispin_r <= enc_dispout;
      case (state_r)
        ST_IDLE: begin
          if (s_valid && (idle_cnt_r >= MIN_IDLE_C)) begin
            enc_datain_r <= SOP_CHAR;
            state_r      <= ST_DATA;
          end else begin
            enc_datain_r <= IDLE_CHAR;
            idle_cnt_r   <= idle_inc(idle_cnt_r);
          end
        end
        ST_DATA: begin
          if (s_valid) begin
            enc_datain_r <= {1'b0, s_data};
            if (s_last) begin
              state_r <= ST_EOP;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            // Upstream starved mid-packet: pad, never terminate early.
            enc_datain_r <= FILL_CHAR;
          end
        end
        ST_EOP: begin
          enc_datain_r <= EOP_CHAR;
          pkt_cnt_r    <= pkt_cnt_r + 16'd1;
          idle_cnt_r   <= 4'd0;
          state_r      <= ST_IDLE;
        end
        default: begin
          enc_datain_r <= IDLE_CHAR;
          idle_cnt_r   <= 4'd0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky underrun flag; a new FILL wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_r <= 1'b0;
    end else if (fill_s) begin
      underrun_r <= 1'b1;
    end else if (underrun_clr) begin
      underrun_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_8b10b_framer.sv
// tb_tx_8b10b_framer
// Directed plus randomized checks of the framer against a symbol-level
// reference model. The encoder is stood in for by a disparity function that
// knows which 6b/4b sub-blocks are unbalanced.
module tb_tx_8b10b_framer;

  localparam logic [8:0] IDLE = 9'h1BC;
  localparam logic [8:0] SOP  = 9'h1FB;
  localparam logic [8:0] EOP  = 9'h1FD;
  localparam logic [8:0] FILL = 9'h1F7;
  localparam int         MIN_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sym_en = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic [8:0]  enc_datain;
  logic        enc_dispin;
  logic        enc_dispout;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic [15:0] pkt_cnt;

  int total = 0;
  int bad = 0;

  // Reference model state (symbol-stream level)
  bit          m_in_pkt;
  bit          m_close;
  bit          m_disp;
  bit          m_und;
  int          m_gap;
  logic [8:0]  m_sym;
  logic [15:0] m_pkt;

  logic [8:0]  tx_q[$];
  logic [8:0]  obs_log[$];
  int          obs_ready;

  logic [8:0]  exp_basic [10] = '{9'h1BC, 9'h1BC, 9'h1FB, 9'h011, 9'h022,
                                  9'h033, 9'h1FD, 9'h1BC, 9'h1BC, 9'h1FB};
  logic [8:0]  exp_und [7] = '{9'h1FB, 9'h011, 9'h022, 9'h1F7, 9'h1F7,
                               9'h033, 9'h1FD};

  // Running disparity after a symbol: each unbalanced sub-block flips it.
  function automatic logic rd_after(input logic [8:0] sym, input logic rd);
    logic [4:0] lo;
    logic [2:0] hi;
    logic       u6;
    logic       u4;
    lo = sym[4:0];
    hi = sym[7:5];
    if (sym[8] && (lo == 5'd28)) u6 = 1'b1;
    else u6 = (lo inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16, 5'd23,
                          5'd24, 5'd27, 5'd29, 5'd30, 5'd31});
    u4 = (hi inside {3'd0, 3'd4, 3'd7});
    return rd ^ u6 ^ u4;
  endfunction

  assign enc_dispout = rd_after(enc_datain, enc_dispin);

  tx_8b10b_framer #(.MIN_IDLE(MIN_IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .sym_en(sym_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .enc_datain(enc_datain), .enc_dispin(enc_dispin), .enc_dispout(enc_dispout),
    .underrun(underrun), .underrun_clr(underrun_clr), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_pkt = 1'b0; m_close = 1'b0; m_disp = 1'b0; m_und = 1'b0;
    m_gap = 0; m_sym = IDLE; m_pkt = 16'h0000;
  endtask

  // Async reset mid-cycle, check outputs without a clock edge, then release.
  task automatic do_reset();
    rst_n = 1'b0; sym_en = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
    #2;
    chk("rst_datain", 16'(enc_datain), 16'(IDLE));
    chk("rst_dispin", 16'(enc_dispin), 16'h0000);
    chk("rst_underrun", 16'(underrun), 16'h0000);
    chk("rst_pkt_cnt", pkt_cnt, 16'h0000);
    chk("rst_ready", 16'(s_ready), 16'h0000);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check s_ready, advance model, check outputs.
  task automatic step(input bit se, input bit v, input logic [7:0] d, input bit l,
                      input bit clr, output bit acc);
    logic [8:0] nsym;
    bit         fill;
    sym_en = se; s_valid = v; s_data = d; s_last = l; underrun_clr = clr;
    #1;
    chk("s_ready", 16'(s_ready), 16'(se && m_in_pkt));
    if (s_ready === 1'b1) obs_ready++;
    acc  = se && m_in_pkt && v;
    fill = 1'b0;
    nsym = m_sym;
    if (se) begin
      if (m_close) begin
        nsym = EOP; m_pkt = m_pkt + 16'd1; m_gap = 0; m_close = 1'b0;
      end else if (m_in_pkt) begin
        if (v) begin
          nsym = {1'b0, d};
          if (l) begin m_in_pkt = 1'b0; m_close = 1'b1; end
        end else begin
          nsym = FILL; fill = 1'b1;
        end
      end else if (v && (m_gap >= MIN_IDLE)) begin
        nsym = SOP; m_in_pkt = 1'b1;
      end else begin
        nsym = IDLE; m_gap++;
      end
      m_disp = rd_after(m_sym, m_disp);
      m_sym  = nsym;
    end
    if (fill) m_und = 1'b1;
    else if (clr) m_und = 1'b0;
    @(posedge clk); #1;
    if (se) obs_log.push_back(enc_datain);
    chk("enc_datain", 16'(enc_datain), 16'(m_sym));
    chk("enc_dispin", 16'(enc_dispin), 16'(m_disp));
    chk("underrun", 16'(underrun), 16'(m_und));
    chk("pkt_cnt", pkt_cnt, m_pkt);
  endtask

  task automatic gen_pkt(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back({(i == n - 1), 8'($urandom())});
  endtask

  // Present the queued bytes; se_mode 0 = always, 1 = toggle, 2 = random.
  task automatic pump(input int n, input int se_mode, input int drop_pct,
                      input int clr_pct, input bit refill);
    bit         acc, se, v, clr;
    logic [8:0] w;
    for (int i = 0; i < n; i++) begin
      if (refill && (tx_q.size() == 0)) gen_pkt(int'($urandom_range(1, 6)));
      case (se_mode)
        0:       se = 1'b1;
        1:       se = ((i % 2) == 0);
        default: se = ($urandom_range(0, 3) != 0);
      endcase
      v   = (tx_q.size() > 0) && (int'($urandom_range(0, 99)) >= drop_pct);
      w   = (tx_q.size() > 0) ? tx_q[0] : 9'h000;
      clr = (int'($urandom_range(0, 99)) < clr_pct);
      step(se, v, w[7:0], w[8], clr, acc);
      if (acc) void'(tx_q.pop_front());
    end
  endtask

  initial begin
    bit acc;
    int pairs, gap_n, j;

    #1;
    do_reset();

    // Idle disparity: K28.5 toggles the disparity every symbol.
    pump(6, 0, 0, 0, 1'b0);

    // Basic packet from reset, followed by a second one-byte packet.
    do_reset();
    obs_log.delete(); obs_ready = 0;
    tx_q.push_back(9'h011); tx_q.push_back(9'h022); tx_q.push_back(9'h133);
    tx_q.push_back(9'h144);
    pump(10, 0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) chk("basic_seq", 16'(obs_log[i]), 16'(exp_basic[i]));
    chk("basic_ready_cnt", 16'(obs_ready), 16'd3);
    pump(6, 0, 0, 0, 1'b0);
    chk("basic_pkt_cnt", pkt_cnt, 16'd2);

    // Back-to-back packets with sym_en toggling.
    obs_log.delete();
    gen_pkt(3); gen_pkt(2);
    pump(40, 1, 0, 0, 1'b0);
    pairs = 0;
    for (int i = 0; i < obs_log.size(); i++) begin
      if (obs_log[i] == EOP) begin
        gap_n = 0;
        j = i + 1;
        while ((j < obs_log.size()) && (obs_log[j] == IDLE)) begin
          gap_n++; j++;
        end
        if ((j < obs_log.size()) && (obs_log[j] == SOP)) begin
          chk("b2b_gap", 16'(gap_n), 16'd2);
          pairs++;
        end
      end
    end
    chk("b2b_pairs", 16'(pairs), 16'd1);

    // Underrun: two FILLs after 0x22, clear collides with second FILL.
    pump(3, 0, 0, 0, 1'b0);
    obs_log.delete();
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 8'h33, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, acc);
    chk("und_set_wins", 16'(underrun), 16'h0001);
    step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("und_cleared", 16'(underrun), 16'h0000);
    for (int i = 0; i < 7; i++) chk("und_seq", 16'(obs_log[i]), 16'(exp_und[i]));

    // Neutral data: D21.5 leaves the disparity untouched.
    for (int i = 0; i < 4; i++) tx_q.push_back({(i == 3), 8'hB5});
    pump(10, 0, 0, 0, 1'b0);

    // Reset in the middle of a packet, then two idles again before SOP.
    gen_pkt(5);
    pump(5, 0, 0, 0, 1'b0);
    do_reset();
    tx_q.delete();
    obs_log.delete();
    gen_pkt(2);
    pump(6, 0, 0, 0, 1'b0);
    chk("rst_idle0", 16'(obs_log[0]), 16'(IDLE));
    chk("rst_idle1", 16'(obs_log[1]), 16'(IDLE));
    chk("rst_sop", 16'(obs_log[2]), 16'(SOP));

    // Counter wrap from a forced 0xFFFF.
    sym_en = 1'b0;
    force dut.pkt_cnt_r = 16'hFFFF;
    #1;
    release dut.pkt_cnt_r;
    m_pkt = 16'hFFFF;
    chk("wrap_preload", pkt_cnt, 16'hFFFF);
    gen_pkt(1);
    pump(8, 0, 0, 0, 1'b0);
    chk("wrap_zero", pkt_cnt, 16'h0000);

    // Randomized traffic: random strobes, starvation and clears.
    pump(600, 2, 15, 10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
